// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer
// Controller-side sequencer for the adder/accumulator datapath. It takes one
// command at a time over a valid/ready handshake, plays out the control word
// for that command over a fixed multi-cycle sequence, captures the ALU flags
// after arithmetic, and pulses done when each command retires.
// Every output is a flop, so nothing reaches an output combinationally from an
// input. Each output is loaded on the edge that enters the state it belongs to.

module accumulator_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DRIVE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  la_n,
  output logic                  lb_n,
  output logic                  ea,
  output logic                  eu,
  output logic                  sub,
  input  logic                  cf_in,
  input  logic                  zf_in,
  output logic                  cf,
  output logic                  zf,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    EXEC  = 3'd2,
    FLAG  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_LDB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OUT = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  // The drive counter counts down from DRIVE_CYCLES-1 to zero; the legal
  // range of 1..4 hold cycles fits in two bits.
  localparam logic [1:0] DRIVE_LAST = 2'(DRIVE_CYCLES - 1);

  // Control word order used by exec_word: {la_n, lb_n, ea, eu, sub}.
  localparam logic [4:0] WORD_IDLE = 5'b11000;

  state_t     state;
  logic [2:0] op;
  logic [1:0] drive_cnt;

  // Control word asserted during the single EXEC cycle of each opcode.
  // Only one of la_n/lb_n is ever low, and ea/eu are never both high.
  function automatic logic [4:0] exec_word(input logic [2:0] opcode);
    logic [4:0] word;
    word = WORD_IDLE;
    case (opcode)
      OP_LDA:  word = 5'b01000;
      OP_CLR:  word = 5'b01000;
      OP_LDB:  word = 5'b10000;
      OP_ADD:  word = 5'b01010;
      OP_SUB:  word = 5'b01011;
      OP_OUT:  word = 5'b11100;
      default: word = WORD_IDLE;
    endcase
    return word;
  endfunction

  // Sequencer FSM: state, latched opcode, operand bus, control strobes,
  // flags, completion pulse and retire count all advance together here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_NOP;
      drive_cnt <= 2'd0;
      cmd_ready <= 1'b1;
      data_out  <= '0;
      la_n      <= 1'b1;
      lb_n      <= 1'b1;
      ea        <= 1'b0;
      eu        <= 1'b0;
      sub       <= 1'b0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      op_count  <= '0;
    end else begin
      done                     <= 1'b0;
      err                      <= 1'b0;
      {la_n, lb_n, ea, eu, sub} <= WORD_IDLE;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op        <= cmd_op;
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_LDA, OP_LDB: begin
                data_out  <= cmd_data;
                drive_cnt <= DRIVE_LAST;
                state     <= DRIVE;
              end
              OP_CLR: begin
                data_out  <= '0;
                drive_cnt <= DRIVE_LAST;
                state     <= DRIVE;
              end
              OP_ADD, OP_SUB, OP_OUT: begin
                {la_n, lb_n, ea, eu, sub} <= exec_word(cmd_op);
                state                     <= EXEC;
              end
              default: begin
                done     <= 1'b1;
                err      <= (cmd_op == OP_RSV);
                op_count <= op_count + DATA_WIDTH'(1);
                state    <= DONE;
              end
            endcase
          end
        end
        DRIVE: begin
          if (drive_cnt == 2'd0) begin
            {la_n, lb_n, ea, eu, sub} <= exec_word(op);
            state                     <= EXEC;
          end else begin
            drive_cnt <= drive_cnt - 2'd1;
          end
        end
        EXEC: begin
          if (op == OP_ADD || op == OP_SUB) begin
            sub   <= (op == OP_SUB);
            state <= FLAG;
          end else begin
            done     <= 1'b1;
            op_count <= op_count + DATA_WIDTH'(1);
            state    <= DONE;
          end
        end
        FLAG: begin
          cf       <= cf_in;
          zf       <= zf_in;
          done     <= 1'b1;
          op_count <= op_count + DATA_WIDTH'(1);
          state    <= DONE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Testbench for accumulator_sequencer: directed and random commands are fed
// through the handshake; a scoreboard queue holds issued commands and a
// monitor retires them against a command-level reference model on done.

module tb_accumulator_sequencer;

  localparam int DW = 8;
  localparam int DC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] data_out;
  logic          la_n, lb_n, ea, eu, sub;
  logic          cf_in = 1'b0, zf_in = 1'b0;
  logic          cf, zf, done, err;
  logic [DW-1:0] op_count;

  accumulator_sequencer #(.DATA_WIDTH(DW), .DRIVE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .data_out(data_out),
    .la_n(la_n), .lb_n(lb_n), .ea(ea), .eu(eu), .sub(sub),
    .cf_in(cf_in), .zf_in(zf_in), .cf(cf), .zf(zf),
    .done(done), .err(err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] data;
    logic          cfi;
    logic          zfi;
    int            acc_cyc;
  } cmd_t;

  cmd_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state at command granularity
  logic [DW-1:0] m_data = '0;
  logic          m_cf = 1'b0, m_zf = 1'b0;
  logic [DW-1:0] m_count = '0;

  // Monitor-side per-command observations
  int  la_c = 0, lb_c = 0, ea_c = 0, eu_c = 0, sub_c = 0, la_off = -1;
  bit  pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finishSim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Issue one command once the sequencer is ready; optionally keep cmd_valid
  // high with junk op/data while busy to show it is ignored.
  task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] data,
                               input logic cfi, input logic zfi, input bit hold);
    cmd_t c;
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 32'(cmd_ready), 32'd1);
      finishSim();
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cf_in     = cfi;
    zf_in     = zfi;
    c.op = op; c.data = data; c.cfi = cfi; c.zfi = zfi; c.acc_cyc = cyc;
    exp_q.push_back(c);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      cmd_op   = 3'($urandom);
      cmd_data = DW'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  function automatic int exp_latency(input logic [2:0] op);
    case (op)
      3'b001, 3'b010, 3'b110: return 2 + DC;
      3'b011, 3'b100:         return 3;
      3'b101:                 return 2;
      default:                return 1;
    endcase
  endfunction

  // Monitor: per-cycle invariants, strobe tallies, and retirement on done
  always @(negedge clk) begin
    if (rst) begin
      la_c = 0; lb_c = 0; ea_c = 0; eu_c = 0; sub_c = 0; la_off = -1; pend = 0;
    end else begin
      checkOutput("inv_ea_eu", 32'(ea & eu), 32'd0);
      checkOutput("inv_la_lb", 32'(!la_n & !lb_n), 32'd0);
      if (cmd_ready)
        checkOutput("inv_idle_quiet", 32'({!la_n, !lb_n, ea, eu, sub}), 32'd0);
      if (pend) begin
        checkOutput("op_count", 32'(op_count), 32'(m_count));
        checkOutput("ready_after_done", 32'(cmd_ready), 32'd1);
        pend = 0;
      end
      if (!la_n && la_off < 0 && exp_q.size() > 0) la_off = cyc - exp_q[0].acc_cyc;
      la_c += int'(!la_n); lb_c += int'(!lb_n); ea_c += int'(ea);
      eu_c += int'(eu); sub_c += int'(sub);
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          cmd_t e;
          bit is_ld_a, is_alu;
          e = exp_q.pop_front();
          is_alu  = (e.op == 3'b011 || e.op == 3'b100);
          is_ld_a = (e.op == 3'b001 || e.op == 3'b110);
          if (e.op == 3'b001 || e.op == 3'b010) m_data = e.data;
          if (e.op == 3'b110) m_data = '0;
          if (is_alu) begin m_cf = e.cfi; m_zf = e.zfi; end
          m_count = m_count + 1'b1;
          checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(exp_latency(e.op)));
          checkOutput("err", 32'(err), 32'(e.op == 3'b111));
          checkOutput("data_out", 32'(data_out), 32'(m_data));
          checkOutput("cf", 32'(cf), 32'(m_cf));
          checkOutput("zf", 32'(zf), 32'(m_zf));
          checkOutput("la_cycles", 32'(la_c), 32'(is_ld_a || is_alu));
          checkOutput("lb_cycles", 32'(lb_c), 32'(e.op == 3'b010));
          checkOutput("ea_cycles", 32'(ea_c), 32'(e.op == 3'b101));
          checkOutput("eu_cycles", 32'(eu_c), 32'(is_alu));
          checkOutput("sub_cycles", 32'(sub_c), (e.op == 3'b100) ? 32'd2 : 32'd0);
          if (is_ld_a) checkOutput("la_offset", 32'(la_off), 32'(1 + DC));
          if (is_alu)  checkOutput("la_offset", 32'(la_off), 32'd1);
          pend = 1;
        end
        la_c = 0; lb_c = 0; ea_c = 0; eu_c = 0; sub_c = 0; la_off = -1;
      end else begin
        checkOutput("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  // Stimulus sequence: reset, directed commands, mid-command reset, NOP wrap,
  // then randomized commands, then drain and summarize.
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_la_n", 32'(la_n), 32'd1);
    checkOutput("rst_lb_n", 32'(lb_n), 32'd1);
    checkOutput("rst_ea_eu_sub", 32'({ea, eu, sub}), 32'd0);
    checkOutput("rst_flags", 32'({cf, zf}), 32'd0);
    checkOutput("rst_done_err", 32'({done, err}), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);

    applyStimulus(3'b001, 8'h35, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 8'h05, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b010, 8'h03, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b011, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b101, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b111, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 8'hA7, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b110, 8'h00, 1'b0, 1'b0, 1'b1);

    // Abort an LDA in its EXEC cycle with an asynchronous reset
    applyStimulus(3'b001, 8'h5C, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (la_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reached_exec", 32'(la_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_la_n", 32'(la_n), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_op_count", 32'(op_count), 32'd0);
    checkOutput("abort_data_out", 32'(data_out), 32'd0);
    exp_q.delete();
    m_data = '0; m_cf = 1'b0; m_zf = 1'b0; m_count = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) applyStimulus(3'b000, DW'($urandom), 1'b0, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("op_count_wrap", 32'(op_count), 32'd0);

    for (int i = 0; i < 200; i++)
      applyStimulus(3'($urandom_range(0, 7)), DW'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom));

    cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    finishSim();
  end

endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

Control sequencer that drives the adder/accumulator datapath from the controller side. Accepts one command at a time over a valid/ready handshake and generates the datapath control word over a fixed multi-cycle sequence: operand data, active-low A/B load strobes, accumulator and ALU bus enables, and subtract select. It captures the carry/zero flags returned by the ALU and reports completion per command. It sits between a host or test driver and the accumulator datapath, and replaces hand-driven control pins.

## Interface
- DATA_WIDTH, 8, width of operand, data_out and op_count
- DRIVE_CYCLES, 1, cycles operand is held on data_out before a load strobe (legal 1–4); covers the datapath input buffer
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  3  opcode: 000 NOP, 001 LDA, 010 LDB, 011 ADD, 100 SUB, 101 OUT, 110 CLR, 111 reserved
- cmd_data  in  DATA_WIDTH  operand for LDA/LDB
- data_out  out  DATA_WIDTH  operand to datapath input bus
- la_n  out  1  load accumulator A, active low
- lb_n  out  1  load register B, active low
- ea  out  1  accumulator drives bus
- eu  out  1  ALU drives bus
- sub  out  1  ALU subtract select
- cf_in, zf_in  in  1 each  registered ALU carry/zero flags
- cf, zf  out  1 each  captured flags from last ADD/SUB
- done  out  1  one-cycle completion pulse
- err  out  1  pulses with done for reserved opcode
- op_count  out  DATA_WIDTH  retired-command count, wraps

## Operation
- States: IDLE, DRIVE, EXEC, FLAG, DONE.
- Accept occurs when cmd_valid & cmd_ready on a rising edge. At accept, opcode is latched and data_out is loaded with cmd_data (LDA/LDB) or 0 (CLR). For other opcodes data_out is unchanged.
- Transitions from IDLE on accept:
  - LDA/LDB/CLR → DRIVE
  - ADD/SUB/OUT → EXEC
  - NOP/reserved → DONE
- DRIVE: all strobes inactive. Stays DRIVE_CYCLES cycles, then goes to EXEC.
- EXEC (one cycle):
  - LDA/CLR: la_n=0
  - LDB: lb_n=0
  - ADD: eu=1, la_n=0, sub=0
  - SUB: eu=1, la_n=0, sub=1
  - OUT: ea=1
- After EXEC: ADD/SUB → FLAG; all others → DONE.
- FLAG (one cycle): sub is held at its EXEC value, all other strobes inactive. cf/zf are loaded from cf_in/zf_in at the end of FLAG.
- DONE (one cycle): done=1; err=1 only for opcode 111. op_count increments, wrapping 0xFF→0x00. The block always returns to IDLE.
- Idle control word (IDLE, DONE, and any state not listed above): la_n=1, lb_n=1, ea=0, eu=0, sub=0.
- Invariants on every cycle:
  - ea & eu is never 1.
  - la_n and lb_n are never both 0.
  - No strobe is active in IDLE.
- cf/zf hold their value through all non-ALU commands.
- cmd_valid seen while busy is ignored (no buffering). Changes to cmd_op/cmd_data after accept have no effect.

## Timing
- Reset values: cmd_ready=1 (rst low, IDLE), data_out=0, la_n=1, lb_n=1, ea=0, eu=0, sub=0, cf=0, zf=0, done=0, err=0, op_count=0.
- Asserting rst mid-command forces IDLE and the values above immediately (asynchronous). No done is issued and op_count does not increment for the aborted command.
- Latency, counted from the accept edge to the done-high cycle:
  - NOP/reserved: 1
  - OUT: 2
  - ADD/SUB: 3
  - LDA/LDB/CLR: 2+DRIVE_CYCLES
- cmd_ready rises in the cycle after done. Minimum spacing between accepts is latency+1 cycles.
- All outputs are registered. No output has a combinational path from any input.

## Test plan
- Reset: hold rst high 3 cycles, release → all outputs at reset values, cmd_ready=1. Assert rst during EXEC of LDA → la_n=1 immediately, no done, op_count unchanged.
- LDA 0x35, DRIVE_CYCLES=1 → data_out=0x35 from cycle 1, la_n=0 only in cycle 2, done in cycle 3, op_count=1.
- LDA 0x05, LDB 0x03, SUB with model returning cf_in=0, zf_in=0 → eu=1, sub=1, la_n=0 in EXEC, sub held in FLAG, then cf=0, zf=0, done.
- ADD with cf_in=1, zf_in=1, then OUT → cf=1, zf=1 captured; ea=1 for exactly one cycle; flags unchanged after OUT.
- Opcode 111 → done and err pulse together 1 cycle after accept, no strobes. cmd_valid held high throughout a LDA → exactly one accept per completion.
- 256 NOPs → op_count wraps to 0x00. Every cycle checked: ea&eu=0, never la_n=lb_n=0.
